// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit with the HI/LO register pair (E stage).
// Optional MD_FLUSH_EN adds a flush input that aborts an in-flight operation.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       md_op,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             d_md_use,
`ifdef MD_FLUSH_EN
  input  logic             flush,
`endif
  output logic             start,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_we;
  logic             flush_i;

`ifdef MD_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic is_mul, is_div;
  assign is_mul = (md_op == 4'd1) || (md_op == 4'd2);
  assign is_div = (md_op == 4'd3) || (md_op == 4'd4);

  assign start    = op_valid & (is_mul | is_div) & ~busy & ~flush_i;
  assign md_stall = d_md_use & (start | busy);

  always_comb begin
    rd_data = '0;
    if (md_op == 4'd7)      rd_data = hi;
    else if (md_op == 4'd8) rd_data = lo;
  end

  // Multiply: extend to 2*WIDTH first so the low 2*WIDTH bits of the
  // product are correct for both signed and unsigned forms.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  always_comb begin
    ext_a = {{WIDTH{1'b0}}, src_a};
    ext_b = {{WIDTH{1'b0}}, src_b};
    if (md_op == 4'd1) begin
      ext_a = {{WIDTH{src_a[WIDTH-1]}}, src_a};
      ext_b = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    end
    prod = ext_a * ext_b;
  end

  // Divide on magnitudes, then fix signs; this also yields the
  // most-negative / -1 result (lo = most-negative, hi = 0) without traps.
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, dvs, uq, ur, quo, rem;
  always_comb begin
    neg_a = (md_op == 4'd3) & src_a[WIDTH-1];
    neg_b = (md_op == 4'd3) & src_b[WIDTH-1];
    mag_a = neg_a ? -src_a : src_a;
    mag_b = neg_b ? -src_b : src_b;
    dvs   = (mag_b == '0) ? WIDTH'(1) : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    quo   = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            busy  <= 1'b1;
            if (is_mul) begin
              {pend_hi, pend_lo} <= prod;
              pend_we            <= 1'b1;
              cnt                <= CW'(MULT_CYCLES);
            end else begin
              pend_hi <= rem;
              pend_lo <= quo;
              pend_we <= (src_b != '0);
              cnt     <= CW'(DIV_CYCLES);
            end
          end else if (op_valid && md_op == 4'd5) begin
            hi <= src_a;
          end else if (op_valid && md_op == 4'd6) begin
            lo <= src_a;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              if (pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
              end
              pend_we <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative-latency multiply/divide unit with the HI/LO register pair, sitting in the E stage beside the ALU.
- Consumes the 4-bit mdOp code produced by the instruction decoder: mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Models configurable multi-cycle latency and raises a stall request toward the D stage while an operation is in flight.
- Generalises the fixed-width mdOp handling to parametrised data width and latencies.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
- op_valid  in  1  E-stage instruction is valid and not bubbled
- src_a  in  WIDTH  rs operand
- src_b  in  WIDTH  rt operand
- d_md_use  in  1  D-stage instruction has nonzero mdOp
- flush  in  1  abort in-flight op (present only with MD_FLUSH_EN)
- start  out  1  combinational: op_valid & md_op∈{1..4} & ~busy
- busy  out  1  registered: operation in flight
- md_stall  out  1  combinational: d_md_use & (start | busy)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- rd_data  out  WIDTH  combinational: hi when md_op=7, lo when md_op=8, else 0

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE.
  - Reset mid-operation discards the pending result.
- States: IDLE and BUSY.
- IDLE, start=1 at an edge:
  - Compute the result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy=1 from the next cycle; go to BUSY.
- BUSY: counter decrements each edge. The edge at which the counter goes 1→0 does all of the following:
  - Writes hi/lo from pending.
  - Clears busy.
  - Returns to IDLE.
- Timing: busy is high for exactly N cycles after the start edge; new hi/lo are visible N cycles after the start edge.
- Arithmetic:
  - mult: signed 2·WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - multu: the same, unsigned.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero (src_b=0): operation still runs the full DIV_CYCLES with busy; hi/lo are left unchanged at completion.
  - Signed overflow (most-negative / −1): lo = most-negative value, hi = 0.
- mthi/mtlo:
  - When op_valid and ~busy, hi (resp. lo) ← src_a at the edge.
  - Ignored while busy.
- mult/div issued while busy: ignored; no restart and no queuing. The pipeline guarantees this does not happen via md_stall.
- mfhi/mflo:
  - rd_data reflects the registered hi/lo; no bypass of a same-cycle mthi/mtlo.
  - While busy, rd_data returns the old values; preventing this is the job of md_stall.
- md_stall: asserted in the start cycle and for every busy cycle whenever the D stage holds any md instruction. This includes mfhi/mflo/mthi/mtlo, which must wait for completion.
- op_valid=0: md_op is ignored entirely, with no state change.

Optional Feature:
- Macro: MD_FLUSH_EN.
- Defined:
  - Adds the flush input.
  - flush=1 at an edge in BUSY → busy=0, counter=0, return to IDLE; hi/lo unchanged and pending result discarded.
  - flush=1 has priority over a simultaneous completion: that result is dropped.
  - flush=1 with start=1 in IDLE → the op is not started.
  - start is forced to 0 while flush=1.
- Undefined: no flush port; every started operation always completes.

Test Plan:
- mult: src_a=0xFFFFFFFE, src_b=3 → busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div: src_a=0xFFFFFFF9 (−7), src_b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with src_a=7, src_b=2 → lo=3, hi=1. divu by src_b=0 → hi/lo unchanged, busy for 10 cycles.
- Stall: mult issued with d_md_use=1 → md_stall=1 in the start cycle plus 5 busy cycles, then 0. Same mult with d_md_use=0 → md_stall=0 throughout.
- mthi src_a=0x1234 → hi=0x1234 next cycle. mflo with md_op=8 → rd_data=lo. mtlo issued while busy → lo unchanged.
- Reset mid-op: start div, deassert rst_n at cycle 4 → busy=0, hi=lo=0 immediately. After release, no late write occurs.
- MD_FLUSH_EN defined: start mult, flush at cycle 5 (the completion edge) → hi/lo keep their prior values, busy=0.
